alarm_fsm: RTL
==============

ALARM_FSM -- requirements
Module: alarm_fsm

Interface
REQ-001 SHALL have parameter T_ARM, default 6, arming delay in seconds.
REQ-002 SHALL have parameter T_DRIVER, default 8, driver-door entry delay in seconds.
REQ-003 SHALL have parameter T_PASS, default 15, passenger-door entry delay in seconds.
REQ-004 SHALL have parameter T_ALARM, default 10, siren hold time in seconds.
REQ-005 SHALL have ports as listed, all inputs synchronous to clk and already debounced upstream:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- one_hz  in  1  one-cycle pulse per second from the shared divider
- ignition  in  1  key on
- door_driver  in  1  1 = open
- door_pass  in  1  1 = open
- hidden_sw  in  1  hidden switch pressed
- brake  in  1  brake pedal pressed
- reprogram  in  1  one-cycle write strobe
- time_param_sel  in  2  0 = arm, 1 = driver, 2 = passenger, 3 = alarm
- time_value  in  4  seconds to store
- status  out  2  LED code: 0 off, 1 solid, 2 blink; consumed by status_generator
- siren  out  1  siren drive
- fuel_pump  out  1  fuel pump enable

Function
REQ-006 SHALL implement states DISARMED, ARMING, ARMED, TRIGGERED and ALARM.
REQ-007 SHALL, in every state, take DISARMED on the next clk while ignition=1; this has priority over all other transitions.
REQ-008 SHALL move DISARMED->ARMING when ignition=0 and door_driver falls 1->0, loading the arm time.
REQ-009 SHALL move ARMING->DISARMED if any door is 1, and ARMING->ARMED on timer expiry.
REQ-010 SHALL, in ARMED, take TRIGGERED with the driver time if door_driver=1, else with the passenger time if door_pass=1; driver wins when both doors are 1.
REQ-011 SHALL move TRIGGERED->ALARM on timer expiry, loading the alarm time; door activity in TRIGGERED is ignored.
REQ-012 SHALL, in ALARM, reload the alarm time every cycle any door is 1, and move ALARM->ARMED on expiry with all doors closed.
REQ-013 SHALL drive status 2 in ARMED, 1 in TRIGGERED and ALARM, and 0 otherwise; siren SHALL be 1 only in ALARM.
REQ-014 SHALL register status and siren so they change exactly 1 clk after the state changes.
REQ-015 SHALL set fuel_pump when ignition=1, hidden_sw=1 and brake=1 in the same cycle, and clear it when ignition=0; fuel_pump SHALL never be 1 while ignition=0.
REQ-016 SHALL keep a 4-bit countdown that loads a value, decrements on each one_hz, and asserts expired when one_hz arrives at count 0.
REQ-017 SHALL treat a loaded value N as expiring on the (N+1)th one_hz; N=0 SHALL expire on the first one_hz.
REQ-018 SHALL let a load and a one_hz in the same cycle take the load, with no decrement.
REQ-019 SHALL, on reprogram=1, write time_value into the register selected by time_param_sel on that clk; a countdown already running keeps its loaded value.
REQ-020 SHALL, when reprogram coincides with a load of the same parameter, load the old value.

Reset
REQ-021 SHALL, while reset=0, asynchronously force state DISARMED, status=0, siren=0, fuel_pump=0 and count=0.
REQ-022 SHALL, while reset=0, set the four time registers to T_ARM, T_DRIVER, T_PASS and T_ALARM.
REQ-023 SHALL, after release mid-operation, act on nothing seen before reset, including any pending door edge.

Structure
REQ-024 SHALL take the state encoding, the status codes (OFF=0, SOLID=1, BLINK=2) and the time_param_sel codes from a shared package also used by status_generator.
REQ-025 SHALL place the countdown in one sub-module, countdown_timer, with ports clk, reset, one_hz, load, value[3:0] and expired.

Verification
REQ-026 SHALL cover arming: ignition=0, door_driver 1->0, then 7 one_hz pulses -> ARMED, status=2.
REQ-027 SHALL cover the driver entry path: ARMED, door_driver=1 -> status=1 one clk later; after 9 one_hz -> siren=1.
REQ-028 SHALL cover both doors opening together in ARMED -> driver time 8 is used, so siren=1 after the 9th one_hz, not the 16th.
REQ-029 SHALL cover ALARM with a door held open for 20 s -> siren stays 1; door closed -> ARMED after 11 one_hz.
REQ-030 SHALL cover reprogramming: reprogram with sel=0 and value=2, then arming -> ARMED after 3 one_hz; and ignition=1 in ALARM -> DISARMED, siren=0.
REQ-031 SHALL cover the fuel pump and reset: ignition, hidden_sw and brake all 1 -> fuel_pump=1; ignition=0 -> 0; reset pulsed in TRIGGERED -> all outputs 0 at once.

Source files
------------

// File: rtl/alarm_fsm_pkg.sv
// Shared encodings for the vehicle alarm controller and status_generator.
// Holds the state encoding, LED status codes and the time register select codes.
package alarm_fsm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_ARMING    = 3'd1,
        ST_ARMED     = 3'd2,
        ST_TRIGGERED = 3'd3,
        ST_ALARM     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OFF   = 2'd0,
        STATUS_SOLID = 2'd1,
        STATUS_BLINK = 2'd2
    } status_t;

    localparam logic [1:0] SEL_ARM    = 2'd0;
    localparam logic [1:0] SEL_DRIVER = 2'd1;
    localparam logic [1:0] SEL_PASS   = 2'd2;
    localparam logic [1:0] SEL_ALARM  = 2'd3;

    function automatic status_t status_of(input state_t s);
        case (s)
            ST_ARMED:     return STATUS_BLINK;
            ST_TRIGGERED: return STATUS_SOLID;
            ST_ALARM:     return STATUS_SOLID;
            default:      return STATUS_OFF;
        endcase
    endfunction

endpackage

// File: rtl/alarm_fsm_countdown_timer.sv
// 4-bit seconds countdown: a value N loaded here expires on the (N+1)th one_hz.
// Load wins over a coincident one_hz; the count holds at zero once drained.
module countdown_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_hz,
    input  logic       load,
    input  logic [3:0] value,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= value;
        end else if (one_hz && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Not gated by load: the FSM derives load from expired, and it already
    // gives its own loads priority over expiry.
    assign expired = one_hz && (count == 4'd0);

endmodule

// File: rtl/alarm_fsm.sv
// Vehicle anti-theft controller: arming/entry/siren sequencing, programmable
// delay registers and the fuel pump interlock.
//
// state        | meaning
// -------------+--------------------------------------------------
// DISARMED     | ignition on or idle, waiting for driver door to close
// ARMING       | arm delay running, any door opening aborts
// ARMED        | watching doors, status LED blinks
// TRIGGERED    | entry delay running, doors ignored
// ALARM        | siren on, held while any door is open
module alarm_fsm
    import alarm_fsm_pkg::*;
#(
    parameter int T_ARM    = 6,
    parameter int T_DRIVER = 8,
    parameter int T_PASS   = 15,
    parameter int T_ALARM  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_hz,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       hidden_sw,
    input  logic       brake,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic [1:0] status,
    output logic       siren,
    output logic       fuel_pump
);

    localparam logic [3:0] ARM_RST    = 4'(T_ARM);
    localparam logic [3:0] DRIVER_RST = 4'(T_DRIVER);
    localparam logic [3:0] PASS_RST   = 4'(T_PASS);
    localparam logic [3:0] ALARM_RST  = 4'(T_ALARM);

    state_t     state_q, state_d;
    logic [3:0] t_arm, t_driver, t_pass, t_alarm;
    logic       door_driver_q;
    logic       timer_load;
    logic [3:0] timer_value;
    logic       expired;
    logic       pump_q;
    status_t    status_q;
    logic       siren_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_arm    <= ARM_RST;
            t_driver <= DRIVER_RST;
            t_pass   <= PASS_RST;
            t_alarm  <= ALARM_RST;
        end else if (reprogram) begin
            case (time_param_sel)
                SEL_ARM:    t_arm    <= time_value;
                SEL_DRIVER: t_driver <= time_value;
                SEL_PASS:   t_pass   <= time_value;
                default:    t_alarm  <= time_value;
            endcase
        end
    end

    countdown_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .one_hz  (one_hz),
        .load    (timer_load),
        .value   (timer_value),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_DISARMED;
            door_driver_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            door_driver_q <= door_driver;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_load  = 1'b0;
        timer_value = 4'd0;
        if (ignition) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (door_driver_q && !door_driver) begin
                        state_d     = ST_ARMING;
                        timer_load  = 1'b1;
                        timer_value = t_arm;
                    end
                end
                ST_ARMING: begin
                    if (door_driver || door_pass) begin
                        state_d = ST_DISARMED;
                    end else if (expired) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (door_driver) begin
                        state_d     = ST_TRIGGERED;
                        timer_load  = 1'b1;
                        timer_value = t_driver;
                    end else if (door_pass) begin
                        state_d     = ST_TRIGGERED;
                        timer_load  = 1'b1;
                        timer_value = t_pass;
                    end
                end
                ST_TRIGGERED: begin
                    if (expired) begin
                        state_d     = ST_ALARM;
                        timer_load  = 1'b1;
                        timer_value = t_alarm;
                    end
                end
                ST_ALARM: begin
                    if (door_driver || door_pass) begin
                        timer_load  = 1'b1;
                        timer_value = t_alarm;
                    end else if (expired) begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= STATUS_OFF;
            siren_q  <= 1'b0;
            pump_q   <= 1'b0;
        end else begin
            status_q <= status_of(state_q);
            siren_q  <= (state_q == ST_ALARM);
            if (!ignition) begin
                pump_q <= 1'b0;
            end else if (hidden_sw && brake) begin
                pump_q <= 1'b1;
            end
        end
    end

    // Gate with live ignition so the pump drops in the same cycle the key turns off.
    assign fuel_pump = pump_q && ignition;
    assign status    = status_q;
    assign siren     = siren_q;

endmodule
